// File: rtl/pipelined_instruction_decoder_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the instruction decoder.
// The slave view belongs to the decoder; the master view belongs to the environment around it.
interface pipelined_instruction_decoder_if #(
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          ir;
  logic                 out_valid;
  logic                 out_ready;
  logic                 rw, mw, mb, ma, cs, ps;
  logic [1:0]           md, bs;
  logic [4:0]           fs;
  logic [4:0]           da, aa, ba;
  logic [DATA_W-1:0]    imm;
  logic                 illegal;
  logic                 bubble;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, ir, out_ready,
    input  in_ready, out_valid, rw, mw, mb, ma, cs, ps, md, bs, fs,
           da, aa, ba, imm, illegal, bubble, err_cnt
  );

  modport slave (
    input  in_valid, ir, out_ready,
    output in_ready, out_valid, rw, mw, mb, ma, cs, ps, md, bs, fs,
           da, aa, ba, imm, illegal, bubble, err_cnt
  );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// Registered, handshaked decode stage: opcode -> control word, operand fields, extended
// immediate, one-bubble load-use hazard insertion and a saturating illegal-opcode counter.
module pipelined_instruction_decoder #(
  parameter int DATA_W    = 32,
  parameter int HAZARD_EN = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pipelined_instruction_decoder_if.slave bus
);

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       mb;
    logic       ma;
    logic       cs;
  } ctrl_t;

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_SUB = 7'b0000101;
  localparam logic [6:0] OP_SLT = 7'b1100101;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR  = 7'b0001010;
  localparam logic [6:0] OP_XOR = 7'b0001100;
  localparam logic [6:0] OP_NOT = 7'b0101110;
  localparam logic [6:0] OP_MOV = 7'b1000000;
  localparam logic [6:0] OP_LSL = 7'b0110000;
  localparam logic [6:0] OP_LSR = 7'b0110001;
  localparam logic [6:0] OP_ADI = 7'b0100010;
  localparam logic [6:0] OP_SBI = 7'b0100101;
  localparam logic [6:0] OP_ANI = 7'b0101000;
  localparam logic [6:0] OP_ORI = 7'b0101010;
  localparam logic [6:0] OP_XRI = 7'b0101100;
  localparam logic [6:0] OP_AIU = 7'b1100010;
  localparam logic [6:0] OP_SIU = 7'b1000101;
  localparam logic [6:0] OP_LD  = 7'b0100001;
  localparam logic [6:0] OP_ST  = 7'b0000001;
  localparam logic [6:0] OP_BZ  = 7'b0100000;
  localparam logic [6:0] OP_BNZ = 7'b1100000;
  localparam logic [6:0] OP_JMR = 7'b1100001;
  localparam logic [6:0] OP_JMP = 7'b1000100;
  localparam logic [6:0] OP_JML = 7'b0000111;

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [14:0] raw, input logic sext);
    logic signed [14:0] raw_s;
    raw_s = raw;
    return sext ? DATA_W'(raw_s) : DATA_W'(raw);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [6:0] op;
  logic [4:0] ir_da, ir_aa, ir_ba;
  ctrl_t      ctrl_dec;
  logic       illegal_dec;
  logic signed [DATA_W-1:0] imm_dec;

  assign op    = bus.ir[31:25];
  assign ir_da = bus.ir[24:20];
  assign ir_aa = bus.ir[19:15];
  assign ir_ba = bus.ir[14:10];

  always_comb begin
    ctrl_dec    = '0;
    illegal_dec = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b00010; end
      OP_SUB: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b00101; end
      OP_SLT: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b00101; ctrl_dec.md = 2'b10; end
      OP_AND: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b01000; end
      OP_OR:  begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b01010; end
      OP_XOR: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b01100; end
      OP_NOT: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b01110; end
      OP_MOV: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b00000; end
      OP_LSL: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b10100; end
      OP_LSR: begin ctrl_dec.rw = 1'b1; ctrl_dec.fs = 5'b11000; end
      OP_ADI: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b00010; ctrl_dec.cs = 1'b1; end
      OP_SBI: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b00101; ctrl_dec.cs = 1'b1; end
      OP_ANI: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b01000; end
      OP_ORI: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b01010; end
      OP_XRI: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b01100; end
      OP_AIU: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b00010; end
      OP_SIU: begin ctrl_dec.rw = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.fs = 5'b00101; end
      OP_LD:  begin ctrl_dec.rw = 1'b1; ctrl_dec.md = 2'b01; end
      OP_ST:  ctrl_dec.mw = 1'b1;
      OP_BZ:  begin ctrl_dec.bs = 2'b01; ctrl_dec.mb = 1'b1; ctrl_dec.cs = 1'b1; end
      OP_BNZ: begin ctrl_dec.bs = 2'b01; ctrl_dec.ps = 1'b1; ctrl_dec.mb = 1'b1; ctrl_dec.cs = 1'b1; end
      OP_JMR: ctrl_dec.bs = 2'b10;
      OP_JMP: begin ctrl_dec.bs = 2'b11; ctrl_dec.mb = 1'b1; ctrl_dec.cs = 1'b1; end
      OP_JML: begin
        ctrl_dec.rw = 1'b1; ctrl_dec.bs = 2'b11; ctrl_dec.ma = 1'b1;
        ctrl_dec.mb = 1'b1; ctrl_dec.cs = 1'b1;
      end
      default: illegal_dec = 1'b1;
    endcase
    imm_dec = ext_imm(bus.ir[14:0], ctrl_dec.cs);
  end

  // Stage p1: output register and hazard tracking state
  logic                  vld_p1;
  ctrl_t                 ctrl_p1;
  logic [4:0]            da_p1, aa_p1, ba_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic                  illegal_p1;
  logic                  bubble_p1;
  logic [ERR_CNT_W-1:0]  err_cnt_p1;
  logic                  prev_ld_p1;
  logic [4:0]            prev_da_p1;

  logic can_load, hazard, take, ins_bubble;

  // Register operands only count as sources when the mux selects them (MA/MB = 0).
  assign hazard     = (HAZARD_EN != 0) && bus.in_valid && prev_ld_p1 &&
                      ((!ctrl_dec.ma && (ir_aa == prev_da_p1)) ||
                       (!ctrl_dec.mb && (ir_ba == prev_da_p1)));
  assign can_load   = !vld_p1 || bus.out_ready;
  assign take       = bus.in_valid && can_load && !hazard;
  assign ins_bubble = hazard && can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      da_p1      <= '0;
      aa_p1      <= '0;
      ba_p1      <= '0;
      imm_p1     <= '0;
      illegal_p1 <= 1'b0;
      bubble_p1  <= 1'b0;
      err_cnt_p1 <= '0;
      prev_ld_p1 <= 1'b0;
      prev_da_p1 <= '0;
    end else if (take) begin
      vld_p1     <= 1'b1;
      ctrl_p1    <= ctrl_dec;
      da_p1      <= ir_da;
      aa_p1      <= ir_aa;
      ba_p1      <= ir_ba;
      imm_p1     <= imm_dec;
      illegal_p1 <= illegal_dec;
      bubble_p1  <= 1'b0;
      prev_ld_p1 <= (op == OP_LD);
      prev_da_p1 <= ir_da;
      if (illegal_dec) err_cnt_p1 <= sat_inc(err_cnt_p1);
    end else if (ins_bubble) begin
      vld_p1     <= 1'b1;
      ctrl_p1    <= '0;
      da_p1      <= '0;
      aa_p1      <= '0;
      ba_p1      <= '0;
      imm_p1     <= '0;
      illegal_p1 <= 1'b0;
      bubble_p1  <= 1'b1;
      prev_ld_p1 <= 1'b0;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = can_load && !hazard;
  assign bus.out_valid = vld_p1;
  assign bus.rw        = ctrl_p1.rw;
  assign bus.md        = ctrl_p1.md;
  assign bus.bs        = ctrl_p1.bs;
  assign bus.ps        = ctrl_p1.ps;
  assign bus.mw        = ctrl_p1.mw;
  assign bus.fs        = ctrl_p1.fs;
  assign bus.mb        = ctrl_p1.mb;
  assign bus.ma        = ctrl_p1.ma;
  assign bus.cs        = ctrl_p1.cs;
  assign bus.da        = da_p1;
  assign bus.aa        = aa_p1;
  assign bus.ba        = ba_p1;
  assign bus.imm       = imm_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.bubble    = bubble_p1;
  assign bus.err_cnt   = err_cnt_p1;

endmodule

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
Registered, handshaked decode stage for the RISC CPU datapath. It takes 32-bit instruction words from fetch, decodes the 7-bit opcode into the 15-bit control word, and extracts register addresses and an extended immediate. It detects load-use hazards and inserts one bubble (NOP) when needed. It flags illegal opcodes and keeps a saturating error count. It sits between instruction fetch and the register file/execute stage.

Parameters:
DATA_W, 32, width of the extended immediate output (must be >= 15)
HAZARD_EN, 1, 1 = load-use bubble insertion enabled; 0 = never stall for hazards
ERR_CNT_W, 8, width of the illegal-opcode counter

Ports:
clk  in  1  single clock domain, rising edge
rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
in_valid  in  1  fetch presents IR
in_ready  out  1  decoder accepts IR this cycle
ir  in  32  instruction: [31:25] opcode, [24:20] DA, [19:15] AA, [14:10] BA, [14:0] immediate
out_valid  out  1  decoded beat valid
out_ready  in  1  execute accepts beat
rw, mw, mb, ma, cs, ps  out  1 each  control bits
md, bs  out  2 each  control fields
fs  out  5  function select
da, aa, ba  out  5 each  register addresses
imm  out  DATA_W  ir[14:0] extended: sign-extended if cs=1, otherwise zero-filled
illegal  out  1  beat came from an undefined opcode
bubble  out  1  beat is a hazard-inserted NOP
err_cnt  out  ERR_CNT_W  saturating count of illegal beats

Behaviour:
- Control word packing, MSB to LSB: RW, MD, BS, PS, MW, FS, MB, MA, CS. Defaults are all 0.
- R-type (RW=1): ADD 0000010 FS=00010; SUB 0000101 FS=00101; SLT 1100101 FS=00101 MD=10; AND 0001000 FS=01000; OR 0001010 FS=01010; XOR 0001100 FS=01100; NOT 0101110 FS=01110; MOV 1000000 FS=00000; LSL 0110000 FS=10100; LSR 0110001 FS=11000.
- Immediate (RW=1, MB=1): ADI 0100010 FS=00010 CS=1; SBI 0100101 FS=00101 CS=1; ANI 0101000 FS=01000; ORI 0101010 FS=01010; XRI 0101100 FS=01100; AIU 1100010 FS=00010; SIU 1000101 FS=00101.
- Memory: LD 0100001 RW=1 MD=01; ST 0000001 MW=1.
- Control flow: BZ 0100000 BS=01 MB=1 CS=1; BNZ 1100000 BS=01 PS=1 MB=1 CS=1; JMR 1100001 BS=10; JMP 1000100 BS=11 MB=1 CS=1; JML 0000111 RW=1 BS=11 MA=1 MB=1 CS=1.
- NOP 0000000 produces an all-zero control word.
- Any other opcode: all-zero control word, illegal=1. Never X.
- Output register:
  - in_ready = (!out_valid | out_ready) & !hazard.
  - On in_valid & in_ready, the decoded beat loads into the output register; out_valid=1 next cycle. Latency is 1 cycle.
  - If the register is not reloaded and out_ready=1, out_valid drops to 0.
  - Outputs hold stable while out_valid & !out_ready.
- Hazard tracking:
  - prev_ld is set with prev_da when a non-bubble LD beat is loaded. It is cleared when any other beat (including a bubble) is loaded.
  - hazard = HAZARD_EN & in_valid & prev_ld & ((MA=0 & AA==prev_da) | (MB=0 & BA==prev_da)). MA and MB are taken from the incoming decode.
  - When hazard is asserted and the register can load, it loads a bubble: all-zero control, bubble=1, addresses 0, imm 0. The input is not taken.
  - The next cycle has hazard=0 and the instruction loads normally. Exactly one bubble is inserted per hazard.
- Error counter: err_cnt increments when an illegal beat loads into the output register. It saturates at all-ones.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0, all control outputs 0, da/aa/ba/imm 0, illegal=0, bubble=0, err_cnt=0, prev_ld=0.
  - in_ready = 1 once reset is released.

Test Plan:
- ADD ir=0x0420_8C00 with out_ready=1 -> next cycle out_valid=1, rw=1, fs=00010, mb=0, da=2, aa=1, ba=3. in_ready stays 1 (back-to-back issue).
- ADI with ir[14:0]=0x7FFF, then AIU with the same immediate, DATA_W=32 -> imm=0xFFFFFFFF (cs=1), then imm=0x00007FFF (cs=0).
- LD DA=4, then ADD AA=4 -> one bubble beat (bubble=1, all control 0), in_ready=0 for that cycle, then the ADD beat. Repeat with HAZARD_EN=0 -> no bubble.
- out_ready held 0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no beat lost or duplicated.
- Opcode 0x7F repeated 300 times with ERR_CNT_W=8 -> illegal=1 and zero control on each beat; err_cnt saturates at 255.
- rst_n pulsed low during a hazard stall -> out_valid, prev_ld and err_cnt cleared immediately. The following ADD decodes with no bubble.
